row_group_reset_seq: RTL

//  Sits between the layer core's per-row resn outputs and the shared board reset pins (one pin per group of 4 rows).

---
 rtl/compair_fee_pkg.sv | 28 ++
 rtl/row_group_reset_fsm.sv | 123 ++++++++++++
 rtl/row_group_reset_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/compair_fee_pkg.sv
//============================================================================
// Module      : compair_fee_pkg
// Description : Shared types and constants for the CompAIR front-end
//               electronics. The row-group reset sequencer uses the group
//               FSM state encoding and the default row/group geometry.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package compair_fee_pkg;

  // Per-group reset sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_REL = 2'd2,
    SETTLE   = 2'd3
  } rst_grp_state_e;

  localparam int COMPAIR_N_ROWS     = 20;
  localparam int COMPAIR_GROUP_SIZE = 4;

  // Width of the optional per-group pulse counter
  localparam int PULSE_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/row_group_reset_fsm.sv
//============================================================================
// Module      : row_group_reset_fsm
// Description : Reset sequencer for one group of rows sharing a board reset
//               pin. Holds the pin low for a minimum width, waits for a
//               release grant from the shared arbiter, then runs a settle
//               window before returning to IDLE.
// Ports       : sysclk          - system clock
//               warm_resn       - asynchronous active-low reset
//               i_req           - group reset request (all rows requesting)
//               i_grant         - release grant from the shared arbiter
//               o_rel_req       - this group asks for a release slot
//               o_resn          - registered board reset pin, active-low
//               o_busy          - FSM is not in IDLE
//               i_pulse_cnt_clr - clear pulse counter (ROW_RESET_PULSE_CNT_EN)
//               o_pulse_cnt     - saturating pulse count (ROW_RESET_PULSE_CNT_EN)
// Config      : ROW_RESET_PULSE_CNT_EN adds the pulse counter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module row_group_reset_fsm
  import compair_fee_pkg::*;
#(
  parameter int MIN_PULSE_CYCLES = 100,
  parameter int SETTLE_CYCLES    = 50
) (
  input  logic sysclk,
  input  logic warm_resn,
  input  logic i_req,
  input  logic i_grant,
  output logic o_rel_req,
  output logic o_resn,
  output logic o_busy
`ifdef ROW_RESET_PULSE_CNT_EN
  ,
  input  logic                   i_pulse_cnt_clr,
  output logic [PULSE_CNT_W-1:0] o_pulse_cnt
`endif
);

  localparam int MAX_CYC = (MIN_PULSE_CYCLES > SETTLE_CYCLES) ? MIN_PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  rst_grp_state_e   r_state;
  rst_grp_state_e   w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_run;
  logic             r_resn;
  logic             w_resn_next;

  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      r_state <= ASSERT;
      r_cnt   <= '0;
      r_resn  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_resn  <= w_resn_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (w_cnt_run) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_run = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) w_next = ASSERT;
      end
      ASSERT: begin
        // Request is ignored here: the minimum width always completes.
        if (r_cnt == ASSERT_LAST) w_next = WAIT_REL;
        else                      w_cnt_run = 1'b1;
      end
      WAIT_REL: begin
        if (!i_req && i_grant) w_next = SETTLE;
      end
      SETTLE: begin
        if (i_req)                     w_next = ASSERT;
        else if (r_cnt == SETTLE_LAST) w_next = IDLE;
        else                           w_cnt_run = 1'b1;
      end
      default: w_next = IDLE;
    endcase
    // The pin lags ASSERT entry by one cycle but rises together with the
    // WAIT_REL -> SETTLE transition, so the low width equals exactly the
    // ASSERT dwell when the release is granted immediately.
    w_resn_next = !((r_state == ASSERT) || ((r_state == WAIT_REL) && (w_next == WAIT_REL)));
  end

  assign o_rel_req = (r_state == WAIT_REL) && !i_req;
  assign o_resn    = r_resn;
  assign o_busy    = (r_state != IDLE);

`ifdef ROW_RESET_PULSE_CNT_EN
  logic                   w_pulse_inc;
  logic [PULSE_CNT_W-1:0] r_pulse_cnt;

  // Only request-driven entries count; the post-reset pulse starts in ASSERT.
  assign w_pulse_inc = ((r_state == IDLE) || (r_state == SETTLE)) && (w_next == ASSERT);

  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      r_pulse_cnt <= '0;
    end else if (i_pulse_cnt_clr) begin
      r_pulse_cnt <= '0;
    end else if (w_pulse_inc && (r_pulse_cnt != '1)) begin
      r_pulse_cnt <= r_pulse_cnt + PULSE_CNT_W'(1);
    end
  end

  assign o_pulse_cnt = r_pulse_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/row_group_reset_seq.sv
//============================================================================
// Module      : row_group_reset_seq
// Description : Converts per-row reset requests into staggered group reset
//               pulses on the shared board reset pins, and masks the chips'
//               interrupt lines while their group is in reset or settling.
//               N_ROWS must be an exact multiple of GROUP_SIZE.
// Ports       : sysclk          - system clock, 100 MHz
//               warm_resn       - asynchronous active-low reset
//               row_resn_req_i  - per-row reset request, active-low
//               row_intn_pin_i  - chip interruptn pins, asynchronous
//               row_intn_o      - synchronised, masked interruptn to core
//               group_resn_o    - board reset pins, active-low, registered
//               group_busy_o    - group FSM not in IDLE
//               pulse_cnt_clr_i - clear all pulse counters (ROW_RESET_PULSE_CNT_EN)
//               pulse_cnt_o     - 8-bit pulse count per group (ROW_RESET_PULSE_CNT_EN)
// Config      : ROW_RESET_PULSE_CNT_EN adds the per-group pulse counters.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module row_group_reset_seq
  import compair_fee_pkg::*;
#(
  parameter int N_ROWS           = COMPAIR_N_ROWS,
  parameter int GROUP_SIZE       = COMPAIR_GROUP_SIZE,
  parameter int MIN_PULSE_CYCLES = 100,
  parameter int SETTLE_CYCLES    = 50,
  parameter int STAGGER_CYCLES   = 20
) (
  input  logic                             sysclk,
  input  logic                             warm_resn,
  input  logic [N_ROWS-1:0]                row_resn_req_i,
  input  logic [N_ROWS-1:0]                row_intn_pin_i,
  output logic [N_ROWS-1:0]                row_intn_o,
  output logic [N_ROWS/GROUP_SIZE-1:0]     group_resn_o,
  output logic [N_ROWS/GROUP_SIZE-1:0]     group_busy_o
`ifdef ROW_RESET_PULSE_CNT_EN
  ,
  input  logic                                         pulse_cnt_clr_i,
  output logic [(N_ROWS/GROUP_SIZE)*PULSE_CNT_W-1:0]   pulse_cnt_o
`endif
);

  localparam int N_GROUPS = N_ROWS / GROUP_SIZE;
  localparam int HOLD_W   = $clog2(STAGGER_CYCLES + 1);

  logic [N_ROWS-1:0]   r_intn_s1;
  logic [N_ROWS-1:0]   r_intn_s2;
  logic [N_GROUPS-1:0] w_req_g;
  logic [N_GROUPS-1:0] w_rel_req;
  logic [N_GROUPS-1:0] w_grant;
  logic [N_GROUPS-1:0] w_busy;
  logic [HOLD_W-1:0]   r_hold;
  logic                w_found;

  // Two-stage synchroniser; idles high so no interrupt is seen out of reset.
  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      r_intn_s1 <= '1;
      r_intn_s2 <= '1;
    end else begin
      r_intn_s1 <= row_intn_pin_i;
      r_intn_s2 <= r_intn_s1;
    end
  end

  // Fixed-priority release arbiter, lowest group index wins.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (!w_found && w_rel_req[g] && (r_hold == '0)) begin
        w_grant[g] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  // Hold-off after each grant so the next release is at least
  // STAGGER_CYCLES later, limiting rail inrush.
  always_ff @(posedge sysclk or negedge warm_resn) begin
    if (!warm_resn) begin
      r_hold <= '0;
    end else if (w_found) begin
      r_hold <= HOLD_W'(STAGGER_CYCLES - 1);
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HOLD_W'(1);
    end
  end

  generate
    for (genvar g = 0; g < N_GROUPS; g++) begin : g_group
      // A group requests only when every row in it requests.
      assign w_req_g[g] = ~|row_resn_req_i[g*GROUP_SIZE +: GROUP_SIZE];

      row_group_reset_fsm #(
        .MIN_PULSE_CYCLES (MIN_PULSE_CYCLES),
        .SETTLE_CYCLES    (SETTLE_CYCLES)
      ) u_fsm (
        .sysclk          (sysclk),
        .warm_resn       (warm_resn),
        .i_req           (w_req_g[g]),
        .i_grant         (w_grant[g]),
        .o_rel_req       (w_rel_req[g]),
        .o_resn          (group_resn_o[g]),
        .o_busy          (w_busy[g])
`ifdef ROW_RESET_PULSE_CNT_EN
        ,
        .i_pulse_cnt_clr (pulse_cnt_clr_i),
        .o_pulse_cnt     (pulse_cnt_o[g*PULSE_CNT_W +: PULSE_CNT_W])
`endif
      );
    end

    for (genvar r = 0; r < N_ROWS; r++) begin : g_row
      assign row_intn_o[r] = w_busy[r/GROUP_SIZE] ? 1'b1 : r_intn_s2[r];
    end
  endgenerate

  assign group_busy_o = w_busy;

endmodule

`default_nettype wire
